// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the UART memory-mapped front end:
// register offsets, STATUS bit positions and the TX drain state encoding.
package uart_mmio_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_DROP    = 5;
  localparam int ST_TX_ACTIVE  = 6;
  localparam int ST_RX_CNT_LSB = 8;
  localparam int ST_TX_CNT_LSB = 16;

  // DATA read value when the RX FIFO has nothing to give
  localparam logic [31:0] RDATA_RX_EMPTY = 32'h0000_0100;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_REQ  = 2'd1,
    D_WAIT = 2'd2
  } drain_state_t;

  function automatic logic [1:0] reg_sel(input logic [3:0] offset);
    return offset[3:2];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Clock-enabled synchronous FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same enabled cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (ce_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ce_i && do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// MMIO front end for the byte UART: TX/RX FIFOs, status, sticky errors.
// Define UART_MMIO_IRQ_EN to build the CTRL register and the level interrupt.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ce_i,
  input  logic [3:0]  addr_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  tx_byte_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic        irq_o
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic             wr_cyc, rd_cyc;
  logic             sel_data, sel_status, sel_ctrl;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [TX_CW-1:0] tx_count;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [RX_CW-1:0] rx_count;
  logic [31:0]      status_w, ctrl_rd;
  logic             unused_bits;

  logic [31:0]  rdata_q, rdata_d;
  logic         rx_valid_q, rx_valid_d;
  logic         rx_ovr_q, rx_ovr_d;
  logic         tx_drop_q, tx_drop_d;
  drain_state_t state_q, state_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic         tx_start_q, tx_start_d;

  // a simultaneous write wins over the read
  assign wr_cyc     = ce_i & wr_en_i;
  assign rd_cyc     = ce_i & rd_en_i & ~wr_en_i;
  assign sel_data   = (addr_i[3:2] == reg_sel(ADDR_DATA));
  assign sel_status = (addr_i[3:2] == reg_sel(ADDR_STATUS));
  assign sel_ctrl   = (addr_i[3:2] == reg_sel(ADDR_CTRL));
  assign unused_bits = ^{wdata_i[31:8], addr_i[1:0]};

  assign tx_push = wr_cyc & sel_data;
  assign rx_push = ce_i & rx_valid_i & ~rx_valid_q;
  assign rx_pop  = rd_cyc & sel_data & ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .ce_i    (ce_i),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (wdata_i[7:0]),
    .dout_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .ce_i    (ce_i),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (rx_byte_i),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  always_comb begin
    status_w = '0;
    status_w[ST_TX_FULL]    = tx_full;
    status_w[ST_TX_EMPTY]   = tx_empty;
    status_w[ST_RX_EMPTY]   = rx_empty;
    status_w[ST_RX_FULL]    = rx_full;
    status_w[ST_RX_OVERRUN] = rx_ovr_q;
    status_w[ST_TX_DROP]    = tx_drop_q;
    status_w[ST_TX_ACTIVE]  = ~tx_empty | (state_q != D_IDLE);
    status_w[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
    status_w[ST_TX_CNT_LSB +: 8] = 8'(tx_count);
  end

  // error flags: write-1-to-clear, but a fresh event in the same cycle wins
  always_comb begin
    rx_valid_d = rx_valid_i;
    rx_ovr_d   = rx_ovr_q;
    tx_drop_d  = tx_drop_q;
    if (wr_cyc && sel_status && wdata_i[ST_RX_OVERRUN]) rx_ovr_d = 1'b0;
    if (wr_cyc && sel_status && wdata_i[ST_TX_DROP])    tx_drop_d = 1'b0;
    if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    if (tx_push && tx_full && !tx_pop) tx_drop_d = 1'b1;

    rdata_d = rdata_q;
    if (rd_cyc) begin
      if (sel_data)        rdata_d = rx_empty ? RDATA_RX_EMPTY : {24'd0, rx_head};
      else if (sel_status) rdata_d = status_w;
      else if (sel_ctrl)   rdata_d = ctrl_rd;
      else                 rdata_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_drop_q  <= 1'b0;
    end else if (ce_i) begin
      rdata_q    <= rdata_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_drop_q  <= tx_drop_d;
    end
  end

  assign rdata_o = rdata_q;

  // Drain FSM
  // state  | meaning
  // D_IDLE | nothing in flight; pops the TX head as soon as one exists
  // D_REQ  | tx_start held with tx_byte until the UART raises tx_busy
  // D_WAIT | frame in progress; waits for tx_busy to fall
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= D_IDLE;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
    end else if (ce_i) begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      D_IDLE:  if (!tx_empty) state_d = D_REQ;
      D_REQ:   if (tx_busy_i) state_d = D_WAIT;
      D_WAIT:  if (!tx_busy_i) state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  always_comb begin
    tx_pop     = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_start_d = tx_start_q;
    case (state_q)
      D_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_head;
          tx_start_d = 1'b1;
        end
      end
      D_REQ:   if (tx_busy_i) tx_start_d = 1'b0;
      default: tx_start_d = 1'b0;
    endcase
  end

  assign tx_byte_o  = tx_byte_q;
  assign tx_start_o = tx_start_q;

`ifdef UART_MMIO_IRQ_EN
  logic [2:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_cyc && sel_ctrl) ctrl_d = wdata_i[2:0];
    irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) |
            (ctrl_q[2] & (rx_ovr_q | tx_drop_q));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else if (ce_i) begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign ctrl_rd = {29'd0, ctrl_q};
  assign irq_o   = irq_q;
`else
  assign ctrl_rd = '0;
  assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_mmio;

  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ce_i = 1'b1;
  logic [3:0]  addr_i = '0;
  logic        wr_en_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic [7:0]  tx_byte_o;
  logic        tx_start_o;
  logic        tx_busy_i = 1'b0;
  logic [7:0]  rx_byte_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        irq_o;

  uart_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ce_i       (ce_i),
    .addr_i     (addr_i),
    .wr_en_i    (wr_en_i),
    .rd_en_i    (rd_en_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .tx_byte_o  (tx_byte_o),
    .tx_start_o (tx_start_o),
    .tx_busy_i  (tx_busy_i),
    .rx_byte_i  (rx_byte_i),
    .rx_valid_i (rx_valid_i),
    .irq_o      (irq_o)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_ovr, m_drop, m_start, m_irq, m_rxv_prev;
  bit   [2:0]  m_ctrl;
  int          m_phase;   // 0 nothing in flight, 1 requesting, 2 UART busy
  logic [31:0] m_rdata;
  logic [7:0]  m_txb;

  // observed DUT handshakes and UART stand-in
  logic [7:0]  dut_log[$];
  bit          prev_start;
  int          u_mode;    // 0 busy low, 1 busy stuck high, 2 frame model
  int          u_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (txq.size() == TXD);
    s[1] = (txq.size() == 0);
    s[2] = (rxq.size() == 0);
    s[3] = (rxq.size() == RXD);
    s[4] = m_ovr;
    s[5] = m_drop;
    s[6] = (txq.size() != 0) || (m_phase != 0);
    s[15:8]  = 8'(rxq.size());
    s[23:16] = 8'(txq.size());
    return s;
  endfunction

  task automatic model_step();
    bit wr, rd, tx_pop, rx_pop, rx_edge;
    int word, txn, rxn;
    if (RST) begin
      txq.delete(); rxq.delete();
      m_ovr = 0; m_drop = 0; m_start = 0; m_irq = 0; m_rxv_prev = 0;
      m_ctrl = '0; m_phase = 0; m_rdata = '0; m_txb = '0;
      return;
    end
    if (!ce_i) return;
    wr = wr_en_i;
    rd = rd_en_i && !wr_en_i;
    word = int'(addr_i[3:2]);
    txn = txq.size();
    rxn = rxq.size();
`ifdef UART_MMIO_IRQ_EN
    m_irq = (m_ctrl[0] && rxn > 0) || (m_ctrl[1] && txn == 0) || (m_ctrl[2] && (m_ovr || m_drop));
`endif
    rx_pop = 0;
    if (rd) begin
      case (word)
        0: if (rxn == 0) m_rdata = 32'h100; else begin m_rdata = {24'h0, rxq[0]}; rx_pop = 1; end
        1: m_rdata = model_status();
`ifdef UART_MMIO_IRQ_EN
        2: m_rdata = {29'h0, m_ctrl};
`else
        2: m_rdata = 32'h0;
`endif
        default: m_rdata = 32'h0;
      endcase
    end
    tx_pop = (m_phase == 0) && (txn > 0);
    case (m_phase)
      0: if (tx_pop) begin m_txb = txq.pop_front(); m_start = 1; m_phase = 1; end
      1: if (tx_busy_i) begin m_start = 0; m_phase = 2; end
      default: if (!tx_busy_i) m_phase = 0;
    endcase
    if (wr && word == 1) begin
      if (wdata_i[4]) m_ovr = 0;
      if (wdata_i[5]) m_drop = 0;
    end
`ifdef UART_MMIO_IRQ_EN
    if (wr && word == 2) m_ctrl = wdata_i[2:0];
`endif
    if (wr && word == 0) begin
      if (txn < TXD || tx_pop) txq.push_back(wdata_i[7:0]);
      else m_drop = 1;
    end
    rx_edge = rx_valid_i && !m_rxv_prev;
    m_rxv_prev = rx_valid_i;
    if (rx_pop) void'(rxq.pop_front());
    if (rx_edge) begin
      if (rxn < RXD || rx_pop) rxq.push_back(rx_byte_i);
      else m_ovr = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check("rdata", rdata_o, m_rdata);
    check("tx_start", {31'h0, tx_start_o}, {31'h0, m_start});
    check("tx_byte", {24'h0, tx_byte_o}, {24'h0, m_txb});
    check("irq", {31'h0, irq_o}, {31'h0, m_irq});
    if (tx_start_o && !prev_start) dut_log.push_back(tx_byte_o);
    prev_start = tx_start_o;
    case (u_mode)
      0: tx_busy_i = 1'b0;
      1: tx_busy_i = 1'b1;
      default: begin
        if (u_cnt == 0 && tx_start_o) u_cnt = 6;
        else if (u_cnt > 0) u_cnt--;
        tx_busy_i = (u_cnt >= 1 && u_cnt <= 3);
      end
    endcase
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; wr_en_i = 1'b1; rd_en_i = 1'b0;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    addr_i = a; rd_en_i = 1'b1; wr_en_i = 1'b0;
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_byte_i = b; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    tick();
  endtask

  task automatic wait_tx_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (txq.size() == 0 && m_phase == 0 && u_cnt == 0) break;
      tick();
    end
    check("tx_drain_timeout", {31'h0, (i < budget)}, 32'h1);
  endtask

  logic [7:0] exp_b[17];

  initial begin
    u_mode = 2; u_cnt = 0; prev_start = 0;

    // reset state
    tick(); tick();
    RST = 1'b0;
    tick();
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_tx_start", {31'h0, tx_start_o}, 32'h0);
    check("reset_irq", {31'h0, irq_o}, 32'h0);

    // three bytes through the UART handshake, in order
    dut_log.delete();
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    bus_write(4'h0, 32'h43);
    wait_tx_idle(200);
    tick();
    check("tx_seq_len", dut_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] v;
      v = (i < dut_log.size()) ? dut_log[i] : 8'hxx;
      check("tx_seq_byte", {24'h0, v}, 32'h41 + i);
    end
    bus_read(4'h4);
    check("status_after_tx", rdata_o, 32'h0000_0006);

    // TX overflow with the UART stuck busy: one byte is in flight, 16 queued, 1 dropped
    u_mode = 1; tx_busy_i = 1'b1;
    for (int i = 0; i < 18; i++) bus_write(4'h0, 32'h60 + i);
    bus_read(4'h4);
    check("status_tx_full", rdata_o, 32'h0010_0065);
    bus_write(4'h4, 32'h20);
    bus_read(4'h4);
    check("status_drop_clr", rdata_o, 32'h0010_0045);
    u_mode = 2; tx_busy_i = 1'b0; u_cnt = 0;
    wait_tx_idle(600);

    // rx_valid held for several cycles gives one byte
    rx_byte_i = 8'h5A; rx_valid_i = 1'b1;
    repeat (4) tick();
    rx_valid_i = 1'b0;
    tick();
    bus_read(4'h4);
    check("status_rx_one", rdata_o, 32'h0000_0102);
    bus_read(4'h0);
    check("rx_data_5a", rdata_o, 32'h0000_005A);
    bus_read(4'h0);
    check("rx_data_empty", rdata_o, 32'h0000_0100);

    // RX overrun: 17 bytes, first 16 intact
    for (int i = 0; i < 17; i++) begin
      exp_b[i] = 8'($urandom_range(0, 255));
      rx_pulse(exp_b[i]);
    end
    bus_read(4'h4);
    check("status_rx_ovr", rdata_o, 32'h0000_101A);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'h0);
      check("rx_fill_byte", rdata_o, {24'h0, exp_b[i]});
    end
    bus_write(4'h4, 32'h10);

    // RX full: pop and new capture in the same cycle
    for (int i = 0; i < 16; i++) begin
      exp_b[i] = 8'($urandom_range(0, 255));
      rx_pulse(exp_b[i]);
    end
    rx_byte_i = 8'hC3; rx_valid_i = 1'b1;
    bus_read(4'h0);
    check("rx_pop_push_head", rdata_o, {24'h0, exp_b[0]});
    rx_valid_i = 1'b0;
    tick();
    bus_read(4'h4);
    check("status_rx_full_no_ovr", rdata_o, 32'h0000_100A);
    for (int i = 1; i < 17; i++) begin
      bus_read(4'h0);
      check("rx_pop_push_byte", rdata_o, (i == 16) ? 32'h0000_00C3 : {24'h0, exp_b[i]});
    end

    // reset while a request is pending and 5 bytes queued
    u_mode = 0; tx_busy_i = 1'b0;
    for (int i = 0; i < 6; i++) bus_write(4'h0, 32'h30 + i);
    check("req_pending", {31'h0, tx_start_o}, 32'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_tx_start", {31'h0, tx_start_o}, 32'h0);
    bus_read(4'h4);
    check("rst_status", rdata_o, 32'h0000_0006);
    bus_read(4'h8);
    check("rst_ctrl", rdata_o, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);

    // randomized traffic
    u_mode = 2; u_cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      int op;
      ce_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) rx_valid_i = ~rx_valid_i;
      if (!rx_valid_i) rx_byte_i = 8'($urandom_range(0, 255));
      op = $urandom_range(0, 9);
      addr_i = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wdata_i = $urandom;
      wr_en_i = 1'b0; rd_en_i = 1'b0;
      case (op)
        2, 3: begin addr_i[3:2] = 2'd0; wr_en_i = 1'b1; end
        4:    begin addr_i[3:2] = 2'd1; wr_en_i = 1'b1; end
        5:    begin addr_i[3:2] = 2'd2; wr_en_i = 1'b1; end
        6:    begin addr_i[3:2] = 2'd0; rd_en_i = 1'b1; end
        7:    begin addr_i[3:2] = 2'd1; rd_en_i = 1'b1; end
        8:    rd_en_i = 1'b1;
        9:    begin wr_en_i = 1'b1; rd_en_i = 1'b1; end
        default: ;
      endcase
      tick();
    end
    ce_i = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b0; rx_valid_i = 1'b0;
    wait_tx_idle(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
